note_player: RTL and testbench
==============================

# note_player

Downstream stage of `song_reader` in the music player. It accepts one note at a time (`note`, `duration`, `new_note`) and plays it as a square wave for `duration` beats. It then pulses `note_done` so `song_reader` can issue the next note. Timing pauses while `play` is low.

## Interface
Parameters:
- `BEAT_DIV`, default 1000000: clock cycles per beat, ≥2. Benches use small values.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset; clears all state immediately when low.
- `play`  in  1  high = run, low = pause.
- `note`  in  6  0 = rest; 1..63 = pitch index (1 = A1, 55 Hz).
- `duration`  in  6  note length in beats.
- `new_note`  in  1  one-cycle strobe; `note` and `duration` are valid in this cycle.
- `note_done`  out  1  one-cycle pulse when the note finishes.
- `audio_out`  out  1  square-wave output, registered.
- `busy`  out  1  high in PLAY and DONE.

## Operation
- FSM states: IDLE, PLAY, DONE.
- **IDLE**
  - `new_note` is sampled only in IDLE, regardless of `play`.
  - On `new_note`: latch `note` into `cur_note` and `duration` into `rem_beats`. Clear `beat_cnt`, `tone_cnt` and `audio_out`.
  - Next state is PLAY, or DONE directly if `duration`==0.
- **PLAY**, with `play` high:
  - `beat_cnt` counts 0..BEAT_DIV-1 and wraps.
  - On a wrap, `rem_beats` decrements. A wrap with `rem_beats`==1 moves the FSM to DONE.
- **PLAY**, with `play` low:
  - `beat_cnt`, `tone_cnt` and `rem_beats` hold.
  - `audio_out` is forced 0. Its toggle phase resumes unchanged when `play` returns high.
- **DONE**
  - `note_done`=1 for exactly this cycle, `audio_out`=0.
  - Next state is always IDLE.
- `new_note` in PLAY or DONE is ignored; it is not queued.
- Tone generation:
  - Only when `cur_note`≠0; a rest keeps `audio_out`=0.
  - Octave oct = (cur_note-1)/12 (range 0..5); semitone s = (cur_note-1) mod 12. Implement the division as a comparator chain or case, not a divider.
  - Half-period H = BASE[s] >> oct, where BASE[0..11] = 9091, 8581, 8099, 7645, 7215, 6810, 6428, 6067, 5727, 5405, 5102, 4816. These are clock cycles at 1 MHz.
  - `tone_cnt` is 14 bits and counts 0..H-1. At H-1 it wraps to 0 and `audio_out` toggles.
- Width rules:
  - `beat_cnt` is $clog2(BEAT_DIV) bits.
  - `rem_beats` is 6 bits.
  - No arithmetic exceeds 14 bits.
- Reset values: state IDLE; `note_done`=0, `audio_out`=0, `busy`=0; all counters and latched values 0.
- Reset low mid-note: outputs clear asynchronously; no `note_done` is produced for the aborted note.

## Timing
- Let `new_note` be high in cycle t, with `play` held high and D = `duration`.
  - PLAY occupies cycles t+1 .. t+D·BEAT_DIV.
  - `note_done` is high in cycle t+1+D·BEAT_DIV only.
  - D=0: `note_done` is high in cycle t+1.
- `busy` rises in cycle t+1 and falls in the cycle after `note_done`.
- Each cycle with `play` low during PLAY delays `note_done` by exactly one cycle.
- `audio_out` first goes high in cycle t+1+H, then toggles every H active cycles.
- Earliest next accepted `new_note` is in the cycle after `note_done`. `song_reader` reacts to `note_done`, so there is no overlap.

## Test plan
All scenarios use BEAT_DIV=4 unless stated.
1. Reset with `reset`=0 mid-PLAY → `audio_out`=0, `note_done`=0, `busy`=0 immediately. After release, no `note_done` occurs until a new `new_note`.
2. `note`=1, `duration`=3, `new_note` in cycle t → single `note_done` pulse in cycle t+13; `audio_out` stays 0 (H=9091 exceeds the 12 PLAY cycles).
3. BEAT_DIV=64, `note`=63, `duration`=10 → H=253; `audio_out` rises at t+254, falls at t+507; `note_done` in cycle t+641.
4. `note`=0, `duration`=2 → `audio_out` stays 0 throughout; `note_done` at t+9. Then `duration`=0 → `note_done` at t+1.
5. `note`=5, `duration`=3, `play` low for 5 cycles starting at t+4 → counters freeze and `audio_out`=0 during the pause; `note_done` at t+18.
6. Second `new_note` at t+3 while in PLAY with `duration`=2 → ignored; single `note_done` at t+9; the next `new_note` at t+10 is accepted.

Source files
------------

// File: rtl/note_player.sv
// Plays one note as a square wave for a number of beats and then pulses note_done.
// The tone half-period comes from a 12-entry semitone table shifted right by the octave.
module note_player #(
    parameter int BEAT_DIV = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       play,
    input  logic [5:0] note,
    input  logic [5:0] duration,
    input  logic       new_note,
    output logic       note_done,
    output logic       audio_out,
    output logic       busy
);

    localparam int BW = $clog2(BEAT_DIV);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_DIV - 1);

    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

    state_t          r_state;
    logic [5:0]      r_cur_note;
    logic [5:0]      r_rem_beats;
    logic [BW-1:0]   r_beat_cnt;
    logic [13:0]     r_tone_cnt;
    logic            r_phase;
    logic            r_audio;
    logic            r_done;
    logic            r_busy;

    logic [5:0]      w_idx;
    logic [2:0]      w_oct;
    logic [3:0]      w_semi;
    logic [13:0]     w_base;
    logic [13:0]     w_half;
    logic            w_tone_on;
    logic            w_beat_wrap;
    logic            w_tone_wrap;
    logic            w_phase_nxt;

    // Octave/semitone split of the pitch index, done with range compares instead of a divider.
    always_comb begin
        w_idx  = r_cur_note - 6'd1;
        w_oct  = 3'd0;
        w_semi = w_idx[3:0];
        if (w_idx >= 6'd60) begin
            w_oct  = 3'd5;
            w_semi = 4'(w_idx - 6'd60);
        end else if (w_idx >= 6'd48) begin
            w_oct  = 3'd4;
            w_semi = 4'(w_idx - 6'd48);
        end else if (w_idx >= 6'd36) begin
            w_oct  = 3'd3;
            w_semi = 4'(w_idx - 6'd36);
        end else if (w_idx >= 6'd24) begin
            w_oct  = 3'd2;
            w_semi = 4'(w_idx - 6'd24);
        end else if (w_idx >= 6'd12) begin
            w_oct  = 3'd1;
            w_semi = 4'(w_idx - 6'd12);
        end
    end

    always_comb begin
        case (w_semi)
            4'd0:    w_base = 14'd9091;
            4'd1:    w_base = 14'd8581;
            4'd2:    w_base = 14'd8099;
            4'd3:    w_base = 14'd7645;
            4'd4:    w_base = 14'd7215;
            4'd5:    w_base = 14'd6810;
            4'd6:    w_base = 14'd6428;
            4'd7:    w_base = 14'd6067;
            4'd8:    w_base = 14'd5727;
            4'd9:    w_base = 14'd5405;
            4'd10:   w_base = 14'd5102;
            default: w_base = 14'd4816;
        endcase
    end

    assign w_half      = w_base >> w_oct;
    assign w_tone_on   = (r_cur_note != 6'd0);
    assign w_beat_wrap = (r_beat_cnt == BEAT_LAST);
    assign w_tone_wrap = (r_tone_cnt == w_half - 14'd1);
    assign w_phase_nxt = r_phase ^ (w_tone_on & w_tone_wrap);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cur_note  <= 6'd0;
            r_rem_beats <= 6'd0;
            r_beat_cnt  <= '0;
            r_tone_cnt  <= 14'd0;
            r_phase     <= 1'b0;
            r_audio     <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (new_note) begin
                        r_cur_note  <= note;
                        r_rem_beats <= duration;
                        r_beat_cnt  <= '0;
                        r_tone_cnt  <= 14'd0;
                        r_phase     <= 1'b0;
                        r_audio     <= 1'b0;
                        r_busy      <= 1'b1;
                        if (duration == 6'd0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= PLAY;
                        end
                    end
                end
                PLAY: begin
                    if (play) begin
                        r_beat_cnt <= w_beat_wrap ? '0 : r_beat_cnt + BW'(1);
                        if (w_tone_on) begin
                            r_tone_cnt <= w_tone_wrap ? 14'd0 : r_tone_cnt + 14'd1;
                            r_phase    <= w_phase_nxt;
                        end
                        if (w_beat_wrap) begin
                            r_rem_beats <= r_rem_beats - 6'd1;
                        end
                        if (w_beat_wrap && r_rem_beats == 6'd1) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_audio <= 1'b0;
                        end else begin
                            r_audio <= w_phase_nxt;
                        end
                    end else begin
                        // Paused: counters and phase hold, output is muted.
                        r_audio <= 1'b0;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_audio <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_audio <= 1'b0;
                end
            endcase
        end
    end

    assign note_done = r_done;
    assign audio_out = r_audio;
    assign busy      = r_busy;

endmodule

// File: tb/tb_note_player.sv
// Self-checking bench for note_player: per-scenario tasks compared against an
// arithmetic model of note length, pause stretching and tone half-periods.
module tb_note_player;

    logic       clk = 1'b0;
    logic       reset;
    logic       play;
    logic [5:0] note;
    logic [5:0] duration;
    logic       new_note;
    logic       nd4, au4, bz4;
    logic       nd64, au64, bz64;

    int errors = 0;
    int checks = 0;

    int BASE [0:11] = '{9091, 8581, 8099, 7645, 7215, 6810, 6428, 6067, 5727, 5405, 5102, 4816};

    logic tr_done  [0:1023];
    logic tr_audio [0:1023];
    logic tr_busy  [0:1023];

    note_player #(.BEAT_DIV(4)) dut4 (
        .clk(clk), .reset(reset), .play(play), .note(note), .duration(duration),
        .new_note(new_note), .note_done(nd4), .audio_out(au4), .busy(bz4)
    );

    note_player #(.BEAT_DIV(64)) dut64 (
        .clk(clk), .reset(reset), .play(play), .note(note), .duration(duration),
        .new_note(new_note), .note_done(nd64), .audio_out(au64), .busy(bz64)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit m_play(input int k, input int ps, input int pl);
        return !(k >= ps && k < ps + pl);
    endfunction

    function automatic int m_half(input int n);
        if (n == 0) return 0;
        return BASE[(n - 1) % 12] >> ((n - 1) / 12);
    endfunction

    // Cycle (relative to the strobe) in which note_done is expected.
    function automatic int m_done_k(input int d, input int b, input int ps, input int pl);
        int k = 1;
        int a = 0;
        while (a < d * b) begin
            if (m_play(k, ps, pl)) a++;
            k++;
        end
        return k;
    endfunction

    function automatic bit m_audio(input int k, input int n, input int d, input int b,
                                   input int ps, input int pl);
        int dk = m_done_k(d, b, ps, pl);
        int h  = m_half(n);
        int a  = 0;
        if (h == 0 || k < 2 || k >= dk || !m_play(k - 1, ps, pl)) return 1'b0;
        for (int j = 1; j < k; j++) if (m_play(j, ps, pl)) a++;
        return ((a / h) % 2) == 1;
    endfunction

    // ---------------- stimulus ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; new_note = 1'b0; play = 1'b1;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Strobes a note at k=0 (plus an optional second strobe at extra_k) and records outputs.
    task automatic run(input int n, input int d, input int ps, input int pl,
                       input int extra_k, input bit sel, input int len);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            tr_done[k]  = sel ? nd64 : nd4;
            tr_audio[k] = sel ? au64 : au4;
            tr_busy[k]  = sel ? bz64 : bz4;
            new_note = (k == 0) || (k == extra_k);
            note     = (k == extra_k) ? 6'd7 : 6'(n);
            duration = (k == extra_k) ? 6'd5 : 6'(d);
            play     = m_play(k, ps, pl);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int pulses = 0;
        @(negedge clk);
        checks++; if (nd4 !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", nd4); end
        checks++; if (au4 !== 1'b0) begin errors++; $display("FAIL reset_audio got %b exp 0", au4); end
        checks++; if (bz4 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bz4); end
        reset = 1'b1;
        run(63, 10, 0, 0, -1, 1'b1, 300);
        checks++;
        if (tr_audio[299] !== m_audio(299, 63, 10, 64, 0, 0)) begin
            errors++; $display("FAIL midnote_audio got %b exp %b", tr_audio[299], m_audio(299, 63, 10, 64, 0, 0));
        end
        checks++; if (tr_busy[299] !== 1'b1) begin errors++; $display("FAIL midnote_busy got %b exp 1", tr_busy[299]); end
        new_note = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++; if (au64 !== 1'b0) begin errors++; $display("FAIL async_audio got %b exp 0", au64); end
        checks++; if (bz64 !== 1'b0) begin errors++; $display("FAIL async_busy got %b exp 0", bz64); end
        checks++; if (nd64 !== 1'b0) begin errors++; $display("FAIL async_done got %b exp 0", nd64); end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            if (nd64 === 1'b1 || nd4 === 1'b1 || bz64 !== 1'b0) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL post_reset_activity got %0d exp 0", pulses); end
    endtask

    task automatic test_trace(input string name, input int n, input int d, input int ps,
                              input int pl, input int extra_k, input bit sel, input bit rst);
        int b  = sel ? 64 : 4;
        int dk = m_done_k(d, b, ps, pl);
        bit ea;
        if (rst) do_reset();
        run(n, d, ps, pl, extra_k, sel, (extra_k >= 0) ? dk + 1 : dk + 2);
        for (int k = 0; k < ((extra_k >= 0) ? dk + 1 : dk + 2); k++) begin
            ea = m_audio(k, n, d, b, ps, pl);
            checks++;
            if (tr_done[k] !== (k == dk)) begin
                errors++; $display("FAIL %s done k=%0d got %b exp %b", name, k, tr_done[k], (k == dk));
            end
            checks++;
            if (tr_busy[k] !== (k >= 1 && k <= dk)) begin
                errors++; $display("FAIL %s busy k=%0d got %b exp %b", name, k, tr_busy[k], (k >= 1 && k <= dk));
            end
            checks++;
            if (tr_audio[k] !== ea) begin
                errors++; $display("FAIL %s audio k=%0d got %b exp %b", name, k, tr_audio[k], ea);
            end
        end
    endtask

    task automatic test_long_note();
        test_trace("long_note", 1, 3, 0, 0, -1, 1'b0, 1'b1);
    endtask

    task automatic test_tone();
        checks++; if (m_done_k(10, 64, 0, 0) !== 641) begin errors++; $display("FAIL tone_model got %0d exp 641", m_done_k(10, 64, 0, 0)); end
        test_trace("tone", 63, 10, 0, 0, -1, 1'b1, 1'b1);
        checks++; if (tr_audio[254] !== 1'b1) begin errors++; $display("FAIL tone_rise got %b exp 1", tr_audio[254]); end
        checks++; if (tr_audio[507] !== 1'b0 || tr_audio[506] !== 1'b1) begin
            errors++; $display("FAIL tone_fall got %b%b exp 10", tr_audio[506], tr_audio[507]);
        end
    endtask

    task automatic test_rest();
        test_trace("rest", 0, 2, 0, 0, -1, 1'b0, 1'b1);
        test_trace("zero_dur", 9, 0, 0, 0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_pause();
        test_trace("pause", 5, 3, 4, 5, -1, 1'b0, 1'b1);
        checks++; if (tr_done[18] !== 1'b1) begin errors++; $display("FAIL pause_done18 got %b exp 1", tr_done[18]); end
    endtask

    task automatic test_back_to_back();
        test_trace("ignore", 3, 2, 0, 0, 3, 1'b0, 1'b1);
        test_trace("next_note", 2, 1, 0, 0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int n, d, ps, pl;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            n  = $urandom_range(1, 63);
            d  = $urandom_range(0, 5);
            ps = $urandom_range(1, 250);
            pl = $urandom_range(0, 40);
            test_trace("random", n, d, ps, pl, -1, 1'b1, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b0; play = 1'b1; note = 6'd0; duration = 6'd0; new_note = 1'b0;
        test_reset();
        test_long_note();
        test_tone();
        test_rest();
        test_pause();
        test_back_to_back();
        test_random();
        new_note = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
